// File: rtl/median_pkg.sv
// Shared constants and types for the 3x3 median engine.
package median_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned PIPE_DEPTH = 3;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned WIN_COLS   = 3;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIN_COLS - 1);

    typedef struct packed {
        logic [DATA_W_DEF-1:0] top;
        logic [DATA_W_DEF-1:0] mid;
        logic [DATA_W_DEF-1:0] bot;
    } column_t;

endpackage

// File: rtl/median_3x3_engine_if.sv
// Column-in / median-out bundle between the median controller and the engine.
interface median_3x3_engine_if import median_pkg::*; ;

    logic                  enable_3x3;
    column_t               col;
    logic [DATA_W_DEF-1:0] median;
    logic                  valid;
    logic                  row_done;

    modport master (
        output enable_3x3,
        output col,
        input  median,
        input  valid,
        input  row_done
    );

    modport slave (
        input  enable_3x3,
        input  col,
        output median,
        output valid,
        output row_done
    );

endinterface

// File: rtl/sort3.sv
// Combinational 3-input sorter: three compare-exchange steps give low/mid/high.
module sort3 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_mid,
    output logic [DATA_W-1:0] o_hi
);

    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] tmp;

    always_comb begin
        x0  = i_a;
        x1  = i_b;
        x2  = i_c;
        tmp = '0;
        if (x0 > x1) begin
            tmp = x0;
            x0  = x1;
            x1  = tmp;
        end
        if (x1 > x2) begin
            tmp = x1;
            x1  = x2;
            x2  = tmp;
        end
        if (x0 > x1) begin
            tmp = x0;
            x0  = x1;
            x1  = tmp;
        end
        o_lo  = x0;
        o_mid = x1;
        o_hi  = x2;
    end

endmodule

// File: rtl/median_3x3_engine.sv
// Streaming 3x3 median filter: column shift register feeding a 3-stage
// sort network (column sort, cross-column reduce, final median).
module median_3x3_engine import median_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable_3x3,
    input  logic [DATA_W-1:0] i_col_top,
    input  logic [DATA_W-1:0] i_col_mid,
    input  logic [DATA_W-1:0] i_col_bot,
    output logic [DATA_W-1:0] o_median,
    output logic              o_valid,
    output logic              o_row_done
);

    // Column layout: index 0 = top, 1 = mid, 2 = bot.
    logic [2:0][DATA_W-1:0]      col_in_c;
    logic [2:0][2:0][DATA_W-1:0] win_c;

    logic [CNT_W-1:0]       col_cnt_q, col_cnt_d;
    logic [2:0][DATA_W-1:0] c1_q, c1_d;
    logic [2:0][DATA_W-1:0] c2_q, c2_d;
    logic                   launch_c;

    logic [2:0][DATA_W-1:0] s1_lo_c, s1_mid_c, s1_hi_c;
    logic [2:0][DATA_W-1:0] s1_lo_q, s1_lo_d;
    logic [2:0][DATA_W-1:0] s1_mid_q, s1_mid_d;
    logic [2:0][DATA_W-1:0] s1_hi_q, s1_hi_d;

    logic [DATA_W-1:0] s2_max_lo_q, s2_max_lo_d;
    logic [DATA_W-1:0] s2_med_mid_q, s2_med_mid_d;
    logic [DATA_W-1:0] s2_min_hi_q, s2_min_hi_d;
    logic [DATA_W-1:0] mid_min_c, mid_max_c, mid_upper_c;

    logic [DATA_W-1:0] s3_lo_c, s3_mid_c, s3_hi_c;
    logic              unused_s3;

    logic [PIPE_DEPTH-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]     median_q, median_d;
    logic                  row_done_q, row_done_d;

    assign col_in_c = {i_col_bot, i_col_mid, i_col_top};
    assign win_c    = {col_in_c, c1_q, c2_q};
    assign launch_c = i_enable_3x3 && (col_cnt_q == CNT_FULL);

    // Column shift register and per-row column count.
    always_comb begin
        col_cnt_d = col_cnt_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        if (i_enable_3x3) begin
            c1_d = col_in_c;
            c2_d = c1_q;
            if (col_cnt_q != CNT_FULL) begin
                col_cnt_d = CNT_W'(col_cnt_q + CNT_W'(1));
            end
        end else begin
            col_cnt_d = '0;
        end
    end

    // S1: sort each window column independently.
    for (genvar g = 0; g < 3; g++) begin : g_s1_sort
        sort3 #(.DATA_W(DATA_W)) u_sort3 (
            .i_a   (win_c[g][0]),
            .i_b   (win_c[g][1]),
            .i_c   (win_c[g][2]),
            .o_lo  (s1_lo_c[g]),
            .o_mid (s1_mid_c[g]),
            .o_hi  (s1_hi_c[g])
        );
    end

    always_comb begin
        s1_lo_d  = s1_lo_c;
        s1_mid_d = s1_mid_c;
        s1_hi_d  = s1_hi_c;
    end

    // S2: max of lows, median of mids, min of highs.
    always_comb begin
        s2_max_lo_d = s1_lo_q[0];
        if (s1_lo_q[1] > s2_max_lo_d) s2_max_lo_d = s1_lo_q[1];
        if (s1_lo_q[2] > s2_max_lo_d) s2_max_lo_d = s1_lo_q[2];

        s2_min_hi_d = s1_hi_q[0];
        if (s1_hi_q[1] < s2_min_hi_d) s2_min_hi_d = s1_hi_q[1];
        if (s1_hi_q[2] < s2_min_hi_d) s2_min_hi_d = s1_hi_q[2];

        mid_min_c    = (s1_mid_q[0] < s1_mid_q[1]) ? s1_mid_q[0] : s1_mid_q[1];
        mid_max_c    = (s1_mid_q[0] < s1_mid_q[1]) ? s1_mid_q[1] : s1_mid_q[0];
        mid_upper_c  = (mid_max_c < s1_mid_q[2]) ? mid_max_c : s1_mid_q[2];
        s2_med_mid_d = (mid_min_c > mid_upper_c) ? mid_min_c : mid_upper_c;
    end

    // S3: median of the three reduced values.
    sort3 #(.DATA_W(DATA_W)) u_sort3_final (
        .i_a   (s2_max_lo_q),
        .i_b   (s2_med_mid_q),
        .i_c   (s2_min_hi_q),
        .o_lo  (s3_lo_c),
        .o_mid (s3_mid_c),
        .o_hi  (s3_hi_c)
    );

    assign unused_s3 = ^{s3_lo_c, s3_hi_c};

    // Valid shift and row-end detection: rows are separated by at least two
    // fill columns, so a valid not followed by another marks the row's last.
    always_comb begin
        valid_d    = {valid_q[PIPE_DEPTH-2:0], launch_c};
        median_d   = valid_q[PIPE_DEPTH-2] ? s3_mid_c : '0;
        row_done_d = valid_q[PIPE_DEPTH-1] && !valid_q[PIPE_DEPTH-2];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            col_cnt_q    <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            s1_lo_q      <= '0;
            s1_mid_q     <= '0;
            s1_hi_q      <= '0;
            s2_max_lo_q  <= '0;
            s2_med_mid_q <= '0;
            s2_min_hi_q  <= '0;
            valid_q      <= '0;
            median_q     <= '0;
            row_done_q   <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            s1_lo_q      <= s1_lo_d;
            s1_mid_q     <= s1_mid_d;
            s1_hi_q      <= s1_hi_d;
            s2_max_lo_q  <= s2_max_lo_d;
            s2_med_mid_q <= s2_med_mid_d;
            s2_min_hi_q  <= s2_min_hi_d;
            valid_q      <= valid_d;
            median_q     <= median_d;
            row_done_q   <= row_done_d;
        end
    end

    assign o_median   = median_q;
    assign o_valid    = valid_q[PIPE_DEPTH-1];
    assign o_row_done = row_done_q;

endmodule

// File: tb/tb_median_3x3_engine.sv
// Directed bench for median_3x3_engine: hand-computed medians, latency and row pulses.
module tb_median_3x3_engine;
    import median_pkg::*;

    localparam int unsigned DW = DATA_W_DEF;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    int   med_q[$];
    int   vcyc_q[$];
    int   rd_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_3x3_engine_if bus ();

    median_3x3_engine #(.DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable_3x3 (bus.enable_3x3),
        .i_col_top    (bus.col.top),
        .i_col_mid    (bus.col.mid),
        .i_col_bot    (bus.col.bot),
        .o_median     (bus.median),
        .o_valid      (bus.valid),
        .o_row_done   (bus.row_done)
    );

    // Log every output event with the cycle it was seen in.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            med_q.push_back(int'(bus.median));
            vcyc_q.push_back(cyc);
        end
        if (bus.row_done === 1'b1) rd_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input int t, input int m, input int b);
        bus.enable_3x3 = en;
        bus.col.top    = DW'(t);
        bus.col.mid    = DW'(m);
        bus.col.bot    = DW'(b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
    endtask

    task automatic clear_log();
        med_q.delete();
        vcyc_q.delete();
        rd_q.delete();
    endtask

    int s;

    initial begin
        rst_n = 1'b0;
        bus.enable_3x3 = 1'b1;
        bus.col = '{top: 8'd9, mid: 8'd9, bot: 8'd9};
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(bus.valid), 32'd0);
        check_eq("rst_median", 32'(bus.median), 32'd0);
        check_eq("rst_row_done", 32'(bus.row_done), 32'd0);
        rst_n = 1'b1;
        idle(2);
        check_eq("rst_quiet_after_release", med_q.size(), 0);

        // Constant image, 7 columns of 5/5/5.
        clear_log();
        s = cyc;
        for (int i = 0; i < 7; i++) drive(1'b1, 5, 5, 5);
        idle(8);
        check_eq("const_count", med_q.size(), 5);
        for (int i = 0; i < med_q.size(); i++) check_eq("const_median", med_q[i], 5);
        check_eq("const_first_cycle", vcyc_q[0], s + 5);
        check_eq("const_last_cycle", vcyc_q[vcyc_q.size()-1], s + 9);
        check_eq("const_row_done_count", rd_q.size(), 1);
        check_eq("const_row_done_cycle", rd_q[0], s + 10);

        // Ramp window.
        clear_log();
        s = cyc;
        drive(1'b1, 1, 4, 7);
        drive(1'b1, 2, 5, 8);
        drive(1'b1, 3, 6, 9);
        idle(6);
        check_eq("ramp_count", med_q.size(), 1);
        check_eq("ramp_median", med_q[0], 5);
        check_eq("ramp_cycle", vcyc_q[0], s + 5);
        check_eq("ramp_row_done", rd_q.size(), 1);

        // Impulse noise: hot centre pixel.
        clear_log();
        drive(1'b1, 10, 10, 10);
        drive(1'b1, 10, 255, 10);
        drive(1'b1, 10, 10, 10);
        idle(6);
        check_eq("impulse_hot_count", med_q.size(), 1);
        check_eq("impulse_hot_median", med_q[0], 10);

        // Impulse noise: dark corner pixel.
        clear_log();
        drive(1'b1, 0, 200, 200);
        drive(1'b1, 200, 200, 200);
        drive(1'b1, 200, 200, 200);
        idle(6);
        check_eq("impulse_dark_count", med_q.size(), 1);
        check_eq("impulse_dark_median", med_q[0], 200);

        // Short runs of 1 and 2 columns produce nothing.
        clear_log();
        drive(1'b1, 40, 40, 40);
        idle(1);
        drive(1'b1, 41, 41, 41);
        drive(1'b1, 42, 42, 42);
        idle(6);
        check_eq("short_run_count", med_q.size(), 0);
        check_eq("short_run_row_done", rd_q.size(), 0);

        // Enable gap: 2 columns, 1 idle, 3 columns.
        clear_log();
        drive(1'b1, 50, 50, 50);
        drive(1'b1, 60, 60, 60);
        idle(1);
        s = cyc;
        drive(1'b1, 1, 2, 3);
        drive(1'b1, 4, 5, 6);
        drive(1'b1, 7, 8, 9);
        idle(6);
        check_eq("gap_count", med_q.size(), 1);
        check_eq("gap_median", med_q[0], 5);
        check_eq("gap_cycle", vcyc_q[0], s + 5);
        check_eq("gap_row_done", rd_q.size(), 1);

        // Reset mid-row discards in-flight windows.
        for (int i = 0; i < 5; i++) drive(1'b1, 77, 77, 77);
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0);
        rst_n = 1'b1;
        clear_log();
        s = cyc;
        drive(1'b1, 30, 33, 90);
        drive(1'b1, 31, 34, 91);
        drive(1'b1, 32, 35, 92);
        check_eq("rst_mid_quiet", med_q.size(), 0);
        check_eq("rst_mid_no_row_done", rd_q.size(), 0);
        idle(6);
        check_eq("rst_mid_count", med_q.size(), 1);
        check_eq("rst_mid_median", med_q[0], 34);
        check_eq("rst_mid_cycle", vcyc_q[0], s + 5);
        check_eq("rst_mid_row_done", rd_q.size(), 1);

        // Back-to-back rows: column j is uniform j, so median is j-1.
        clear_log();
        for (int j = 1; j <= 7; j++) drive(1'b1, j, j, j);
        idle(1);
        for (int j = 11; j <= 17; j++) drive(1'b1, j, j, j);
        idle(8);
        check_eq("b2b_count", med_q.size(), 10);
        for (int i = 0; i < 5; i++) check_eq("b2b_row1_median", med_q[i], i + 2);
        for (int i = 5; i < med_q.size(); i++) check_eq("b2b_row2_median", med_q[i], i + 7);
        check_eq("b2b_row_done_count", rd_q.size(), 2);
        check_eq("b2b_row1_done_cycle", rd_q[0], vcyc_q[4] + 1);
        check_eq("b2b_row2_done_cycle", rd_q[1], vcyc_q[9] + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
